oflow_buffer_write_ctrl: RTL and testbench

- Consumer stage directly downstream of the core write-sequencing FSM.
- Accepts 4-bbox beats tagged by row_sel / pe_sel / remainder and stages them in a 2-entry FIFO.
- Writes the beats into the frame MEM buffer, one masked 4-word line per write.
- Counts written bboxes, raises done_write at end of frame, and flags protocol errors.

---
 rtl/oflow_buffer_write_ctrl_pkg.sv | 31 +++
 rtl/oflow_buffer_write_ctrl_if.sv | 35 +++
 rtl/oflow_buffer_wr_fifo.sv | 43 ++++
 rtl/oflow_buffer_write_ctrl.sv | 112 +++++++++++
 tb/tb_oflow_buffer_write_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/oflow_buffer_write_ctrl_pkg.sv
// Shared definitions for the oflow buffer write path: geometry, FSM encoding,
// the staged beat record and mask helpers.
package oflow_core_define;

  localparam int PE_NUM     = 24;
  localparam int GROUPS     = PE_NUM / 4;
  localparam int BBOX_W     = 64;
  localparam int WORDS      = 4;
  localparam int NUM_BBOX_W = 10;
  localparam int ROW_W      = 5;
  localparam int PE_W       = 3;
  localparam int ADDR_W     = 8;

  typedef enum logic [1:0] {IDLE, WRITE, DRAIN, DONE} wr_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]              addr;
    logic [WORDS-1:0]               mask;
    logic [WORDS-1:0][BBOX_W-1:0]   data;
  } beat_t;

  // remainder 0 means a full line; otherwise the low N words are valid
  function automatic logic [WORDS-1:0] rem_to_mask(input logic [1:0] rem);
    return (rem == 2'd0) ? 4'b1111 : 4'((4'd1 << rem) - 4'd1);
  endfunction

  function automatic logic [2:0] mask_pop(input logic [WORDS-1:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

endpackage

// File: rtl/oflow_buffer_write_ctrl_if.sv
// Core-beat handshake plus MEM write port of the oflow buffer write controller.
interface oflow_buffer_write_ctrl_if;
  import oflow_core_define::*;

  logic                       start_frame;
  logic [NUM_BBOX_W-1:0]      num_of_bbox_in_frame;
  logic                       ready_from_core;
  logic [ROW_W-1:0]           row_sel;
  logic [PE_W-1:0]            pe_sel;
  logic [1:0]                 remainder;
  logic [WORDS*BBOX_W-1:0]    beat_data;
  logic                       buffer_ready;
  logic                       mem_busy;
  logic                       mem_wr_en;
  logic [ADDR_W-1:0]          mem_wr_addr;
  logic [WORDS*BBOX_W-1:0]    mem_wr_data;
  logic [WORDS-1:0]           mem_wr_mask;
  logic                       done_write;
  logic                       frame_error;

  modport slave (
    input  start_frame, num_of_bbox_in_frame, ready_from_core, row_sel, pe_sel,
           remainder, beat_data, mem_busy,
    output buffer_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_mask,
           done_write, frame_error
  );

  modport master (
    output start_frame, num_of_bbox_in_frame, ready_from_core, row_sel, pe_sel,
           remainder, beat_data, mem_busy,
    input  buffer_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_mask,
           done_write, frame_error
  );

endinterface

// File: rtl/oflow_buffer_wr_fifo.sv
// Two-entry beat FIFO: 1-bit pointers plus a full flag to tell full from empty.
module oflow_buffer_wr_fifo
  import oflow_core_define::*;
(
  input  logic  clk,
  input  logic  reset_N,
  input  logic  clr,
  input  logic  push,
  input  beat_t din,
  input  logic  pop,
  output beat_t head,
  output logic  full,
  output logic  empty
);

  beat_t mem [2];
  logic  wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr) && !full;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      full   <= 1'b0;
    end else if (clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      // push+pop together keeps occupancy, so full only moves on one-sided ops
      if (push && !pop)      full <= (~wr_ptr == rd_ptr);
      else if (pop && !push) full <= 1'b0;
    end
  end

endmodule

// File: rtl/oflow_buffer_write_ctrl.sv
// Stages tagged 4-bbox beats from the core and writes them as masked lines
// into the frame MEM buffer; tracks frame completion and protocol errors.
module oflow_buffer_write_ctrl
  import oflow_core_define::*;
(
  input  logic clk,
  input  logic reset_N,
  oflow_buffer_write_ctrl_if.slave bus
);

  wr_state_t               state, state_nxt;
  logic [NUM_BBOX_W-1:0]   n_reg;
  logic [NUM_BBOX_W:0]     word_cnt, cnt_sum;
  logic [ADDR_W-1:0]       exp_addr;
  beat_t                   in_beat, head;
  logic                    fifo_full, fifo_empty;
  logic                    buf_rdy, accept, drop, pop, start_ok, err_evt;
  logic                    err_q, done_q, wr_en_q;
  logic [ADDR_W-1:0]       wr_addr_q;
  logic [WORDS-1:0]        wr_mask_q;
  logic [WORDS*BBOX_W-1:0] wr_data_q;

  assign in_beat.addr = ADDR_W'(bus.row_sel) * ADDR_W'(GROUPS) + ADDR_W'(bus.pe_sel);
  assign in_beat.mask = rem_to_mask(bus.remainder);
  assign in_beat.data = bus.beat_data;

  // ready depends on registered state only, never on mem_busy
  assign buf_rdy  = (state == WRITE) && !fifo_full;
  assign accept   = bus.ready_from_core && buf_rdy;
  assign drop     = bus.ready_from_core && !buf_rdy;
  assign pop      = !fifo_empty && !bus.mem_busy;
  assign start_ok = bus.start_frame && (state == IDLE);
  assign cnt_sum  = word_cnt + (NUM_BBOX_W+1)'(mask_pop(in_beat.mask));

  assign err_evt = drop
                 | (bus.start_frame && (state != IDLE))
                 | (accept && (in_beat.addr != exp_addr))
                 | (accept && (cnt_sum > {1'b0, n_reg}));

  oflow_buffer_wr_fifo u_fifo (
    .clk     (clk),
    .reset_N (reset_N),
    .clr     (start_ok),
    .push    (accept),
    .din     (in_beat),
    .pop     (pop),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start_frame)
               state_nxt = (bus.num_of_bbox_in_frame == '0) ? DONE : WRITE;
      WRITE: if (accept && (cnt_sum >= {1'b0, n_reg})) state_nxt = DRAIN;
      DRAIN: if (fifo_empty && !wr_en_q) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state    <= IDLE;
      n_reg    <= '0;
      word_cnt <= '0;
      exp_addr <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == DONE);
      err_q  <= (start_ok ? 1'b0 : err_q) | err_evt;
      if (start_ok) begin
        n_reg    <= bus.num_of_bbox_in_frame;
        word_cnt <= '0;
        exp_addr <= '0;
      end else if (accept) begin
        word_cnt <= cnt_sum;
        exp_addr <= exp_addr + ADDR_W'(1);
      end
    end
  end

  // write port: data holds its last value whenever no pop happens
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_mask_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= pop;
      if (pop) begin
        wr_addr_q <= head.addr;
        wr_mask_q <= head.mask;
        wr_data_q <= head.data;
      end
    end
  end

  assign bus.buffer_ready = buf_rdy;
  assign bus.mem_wr_en    = wr_en_q;
  assign bus.mem_wr_addr  = wr_addr_q;
  assign bus.mem_wr_mask  = wr_mask_q;
  assign bus.mem_wr_data  = wr_data_q;
  assign bus.done_write   = done_q;
  assign bus.frame_error  = err_q;

endmodule

// File: tb/tb_oflow_buffer_write_ctrl.sv
// Directed scoreboard bench: stimulus queues expected writes, a negedge
// monitor pops and compares each MEM write and done_write pulse.
module tb_oflow_buffer_write_ctrl;
  import oflow_core_define::*;

  logic clk = 1'b0;
  logic reset_N = 1'b0;
  always #5 clk = ~clk;

  oflow_buffer_write_ctrl_if bus ();

  oflow_buffer_write_ctrl dut (
    .clk     (clk),
    .reset_N (reset_N),
    .bus     (bus)
  );

  int    errors = 0;
  int    checks = 0;
  int    wr_cnt = 0;
  int    exp_done = 0;
  beat_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WORDS*BBOX_W-1:0] mk(input int seed);
    logic [WORDS-1:0][BBOX_W-1:0] d;
    for (int k = 0; k < WORDS; k++) d[k] = {32'(seed), 32'(k)} ^ 64'hA5A5_0F0F_3C3C_9696;
    return d;
  endfunction

  // monitor: compare every write and done pulse against the scoreboard
  always @(negedge clk) begin
    if (reset_N) begin
      if (bus.mem_wr_en) begin
        beat_t e;
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr %0d mask %b with empty scoreboard",
                   bus.mem_wr_addr, bus.mem_wr_mask);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(bus.mem_wr_addr), 64'(e.addr));
          chk("wr_mask", 64'(bus.mem_wr_mask), 64'(e.mask));
          checks++;
          if (bus.mem_wr_data !== e.data) begin
            errors++;
            $display("FAIL wr_data: got %h expected %h", bus.mem_wr_data, e.data);
          end
        end
      end
      if (bus.done_write) begin
        checks++;
        if (exp_done == 0) begin
          errors++;
          $display("FAIL unexpected_done: done_write=1 expected 0");
        end else begin
          exp_done--;
          chk("done_after_writes", 64'(exp_q.size()), 64'd0);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input int n);
    bus.num_of_bbox_in_frame = NUM_BBOX_W'(n);
    bus.start_frame = 1'b1;
    cyc(1);
    bus.start_frame = 1'b0;
  endtask

  task automatic send(input int row, input int pe, input int rem, input int seed,
                      input int exp_addr, input logic [3:0] exp_mask);
    int    t = 0;
    beat_t e;
    while (!bus.buffer_ready && t < 50) begin
      cyc(1);
      t++;
    end
    checks++;
    if (!bus.buffer_ready) begin
      errors++;
      $display("FAIL send_timeout: buffer_ready=0 expected 1 for addr %0d", exp_addr);
      return;
    end
    bus.row_sel   = ROW_W'(row);
    bus.pe_sel    = PE_W'(pe);
    bus.remainder = 2'(rem);
    bus.beat_data = mk(seed);
    bus.ready_from_core = 1'b1;
    e.addr = ADDR_W'(exp_addr);
    e.mask = exp_mask;
    e.data = mk(seed);
    exp_q.push_back(e);
    cyc(1);
    bus.ready_from_core = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (exp_done != 0 && t < 200) begin
      cyc(1);
      t++;
    end
    checks++;
    if (exp_done != 0) begin
      errors++;
      $display("FAIL %s_timeout: done_write pending=%0d expected 0", name, exp_done);
      exp_done = 0;
    end
    cyc(1);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_wr_en"},    64'(bus.mem_wr_en), 64'd0);
    chk({name, "_ready"},    64'(bus.buffer_ready), 64'd0);
    chk({name, "_done"},     64'(bus.done_write), 64'd0);
    chk({name, "_err"},      64'(bus.frame_error), 64'd0);
    chk({name, "_addr"},     64'(bus.mem_wr_addr), 64'd0);
    chk({name, "_mask"},     64'(bus.mem_wr_mask), 64'd0);
    chk({name, "_data_nz"},  64'(|bus.mem_wr_data), 64'd0);
  endtask

  initial begin
    int wr0;
    bus.start_frame = 1'b0;
    bus.num_of_bbox_in_frame = '0;
    bus.ready_from_core = 1'b0;
    bus.row_sel = '0;
    bus.pe_sel = '0;
    bus.remainder = '0;
    bus.beat_data = '0;
    bus.mem_busy = 1'b0;
    cyc(2);
    chk_idle_outputs("reset");
    reset_N = 1'b1;
    cyc(2);

    // nominal: 12 full beats then a 2-word tail, 50 words total
    start(50);
    exp_done = 1;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 6; p++)
        send(r, p, 0, 100 + r*6 + p, r*6 + p, 4'b1111);
    send(2, 0, 2, 200, 12, 4'b0011);
    wait_done("nominal");
    chk("nominal_writes", 64'(wr_cnt), 64'd13);
    chk("nominal_err", 64'(bus.frame_error), 64'd0);

    // empty frame: done_write two cycles after start, no writes
    wr0 = wr_cnt;
    exp_done = 1;
    start(0);
    chk("empty_done_t1", 64'(bus.done_write), 64'd0);
    cyc(1);
    chk("empty_done_t2", 64'(bus.done_write), 64'd1);
    cyc(1);
    chk("empty_done_t3", 64'(bus.done_write), 64'd0);
    chk("empty_no_write", 64'(wr_cnt - wr0), 64'd0);
    chk("empty_err", 64'(bus.frame_error), 64'd0);
    cyc(2);

    // backpressure: mem_busy for 5 cycles from the first beat
    start(24);
    exp_done = 1;
    bus.mem_busy = 1'b1;
    send(0, 0, 0, 300, 0, 4'b1111);
    send(0, 1, 0, 301, 1, 4'b1111);
    chk("bp_ready_drop", 64'(bus.buffer_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("bp_busy_no_write", 64'(bus.mem_wr_en), 64'd0);
    end
    bus.mem_busy = 1'b0;
    for (int p = 2; p < 6; p++) send(0, p, 0, 300 + p, p, 4'b1111);
    wait_done("backpressure");
    chk("bp_err", 64'(bus.frame_error), 64'd0);

    // drop: beat offered while the FIFO is full must vanish and flag error
    start(8);
    exp_done = 1;
    bus.mem_busy = 1'b1;
    send(0, 0, 0, 400, 0, 4'b1111);
    send(0, 1, 0, 401, 1, 4'b1111);
    bus.row_sel = ROW_W'(3);
    bus.pe_sel = PE_W'(2);
    bus.remainder = 2'd0;
    bus.beat_data = mk(499);
    bus.ready_from_core = 1'b1;
    cyc(1);
    bus.ready_from_core = 1'b0;
    chk("drop_err", 64'(bus.frame_error), 64'd1);
    bus.mem_busy = 1'b0;
    cyc(4);
    chk("drop_err_sticky", 64'(bus.frame_error), 64'd1);
    wait_done("drop");
    chk("drop_err_after_done", 64'(bus.frame_error), 64'd1);

    // address mismatch: second beat lands at pe 3
    start(8);
    chk("mismatch_err_cleared", 64'(bus.frame_error), 64'd0);
    exp_done = 1;
    send(0, 0, 0, 500, 0, 4'b1111);
    send(0, 3, 0, 501, 3, 4'b1111);
    wait_done("mismatch");
    chk("mismatch_err", 64'(bus.frame_error), 64'd1);

    // reset mid-frame after 3 of 6 beats, then a fresh 4-word frame
    start(24);
    for (int p = 0; p < 3; p++) send(0, p, 0, 600 + p, p, 4'b1111);
    cyc(4);
    reset_N = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    cyc(3);
    chk_idle_outputs("midreset_hold");
    reset_N = 1'b1;
    cyc(6);
    start(4);
    exp_done = 1;
    send(0, 0, 0, 700, 0, 4'b1111);
    wait_done("fresh");
    chk("fresh_err", 64'(bus.frame_error), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
